pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register; successor to the fixed-field MEM/WB latch.

---
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush and bubble insertion.
// Define PIPE_STAGE_SKID_EN to get a 2-entry elastic buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int                CTRL_W   = 3,
  parameter int                DATA_W   = 69,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              r_out_valid;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_data;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign out_valid = r_out_valid;
  assign out_ctrl  = r_out_ctrl;
  assign out_data  = r_out_data;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  // in_ready is a flop so that out_ready never reaches upstream combinationally.
  assign in_ready = r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= RST_DATA;
      r_skid_ctrl <= '0;
      r_skid_data <= RST_DATA;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= RST_DATA;
      r_skid_ctrl <= '0;
      r_skid_data <= RST_DATA;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
            r_out_ctrl  <= in_ctrl;
            r_out_data  <= in_data;
          end
        end
        S_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            r_state     <= S_TWO;
            r_in_ready  <= 1'b0;
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
          end else if (w_out_fire && !w_in_fire) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
          end else if (w_in_fire && w_out_fire) begin
            r_out_ctrl  <= in_ctrl;
            r_out_data  <= in_data;
          end
        end
        S_TWO: begin
          // Upstream is blocked here, so only the drain of the skid entry can occur.
          if (w_out_fire) begin
            r_state     <= S_ONE;
            r_in_ready  <= 1'b1;
            r_out_ctrl  <= r_skid_ctrl;
            r_out_data  <= r_skid_data;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_ctrl  <= '0;
        end
      endcase
    end
  end

`else

  assign in_ready = !r_out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= RST_DATA;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= RST_DATA;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_ctrl  <= in_ctrl;
      r_out_data  <= in_data;
    end else if (w_out_fire) begin
      // Bubble: the payload is left as-is, only valid and control are cleared.
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, hand-written corner sequences
// and a random run against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int CW = 3;
  localparam int DW = 69;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl   = '0;
  logic [DW-1:0] in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .RST_DATA('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic          iv;
    logic          ordy;
    logic [CW-1:0] ictrl;
    logic [DW-1:0] idata;
    logic          ev;
    logic [CW-1:0] ectrl;
    logic [DW-1:0] edata;
    logic          chk_data;
  } vec_t;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  vec_t          vecs[10];
  int            vals[3];
  logic [DW-1:0] got[$];
  ent_t          q[$];

  initial begin
    int   idx;
    logic fire;
    logic exp_rdy;
    logic in_f;
    logic out_f;
    logic last_flush;

    // Table: T2 stream of 1..8 at full rate, then T5 single entry followed by a bubble.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b1, CW'(i + 1), DW'(i + 1), 1'b1, CW'(i + 1), DW'(i + 1), 1'b1};
    vecs[8] = '{1'b1, 1'b1, 3'b011, DW'(20), 1'b1, 3'b011, DW'(20), 1'b1};
    vecs[9] = '{1'b0, 1'b1, 3'b000, DW'(0),  1'b0, 3'b000, DW'(0),  1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ctrl",  128'(out_ctrl),  128'(0));
    chk("rst_data",  128'(out_data),  128'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      in_ctrl   = vecs[i].ictrl;
      in_data   = vecs[i].idata;
      @(posedge clk);
      #1;
      $display("vec %0d: in_valid=%0b in_data=%0h -> out_valid=%0b out_ctrl=%0h out_data=%0h",
               i, vecs[i].iv, vecs[i].idata, out_valid, out_ctrl, out_data);
      chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(vecs[i].ev));
      chk($sformatf("vec%0d_ctrl", i),  128'(out_ctrl),  128'(vecs[i].ectrl));
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_data", i), 128'(out_data), 128'(vecs[i].edata));
    end

    // T3: stall with 5,6,7 offered, then release
    vals = '{5, 6, 7};
    idx  = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (idx < 3);
      in_ctrl   = 3'b001;
      in_data   = (idx < 3) ? DW'(vals[idx]) : '0;
      #1;
      if (c == 1) chk("t3_in_ready_c1", 128'(in_ready), 128'(SKID));
      if (c == 2) chk("t3_in_ready_c2", 128'(in_ready), 128'(0));
      fire = in_valid & in_ready;
      @(posedge clk);
      if (fire) idx++;
      #1;
      $display("t3 stall %0d: out_valid=%0b out_data=%0h", c, out_valid, out_data);
      chk($sformatf("t3_stall%0d_valid", c), 128'(out_valid), 128'(1));
      chk($sformatf("t3_stall%0d_data", c),  128'(out_data),  128'(5));
    end
    got.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? DW'(vals[idx]) : '0;
      #1;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        $display("t3 deliver: out_data=%0h", out_data);
      end
      fire = in_valid & in_ready;
      @(posedge clk);
      if (fire) idx++;
      if (got.size() == 3) break;
    end
    chk("t3_count", 128'(got.size()), 128'(3));
    for (int k = 0; k < 3; k++)
      if (k < got.size()) chk($sformatf("t3_order%0d", k), 128'(got[k]), 128'(vals[k]));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);

    // T4: flush with entries held and a simultaneous offered entry
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 3'b010;
    in_data   = DW'(11);
    @(negedge clk);
    in_data = DW'(12);
    @(negedge clk);
    chk("t4_held_valid", 128'(out_valid), 128'(1));
    flush   = 1'b1;
    in_ctrl = 3'b111;
    in_data = DW'(9);
    @(posedge clk);
    #1;
    $display("t4 flush: out_valid=%0b out_ctrl=%0h out_data=%0h", out_valid, out_ctrl, out_data);
    chk("t4_valid", 128'(out_valid), 128'(0));
    chk("t4_ctrl",  128'(out_ctrl),  128'(0));
    chk("t4_data",  128'(out_data),  128'(0));
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t4_in_ready", 128'(in_ready), 128'(1));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t4_nothing%0d", c), 128'(out_valid), 128'(0));
    end

    // T1: reset asserted mid-stream, between clock edges
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 3'b101;
    in_data   = DW'(33);
    @(posedge clk);
    #1;
    chk("t1_pre_valid", 128'(out_valid), 128'(1));
    #1;
    rst = 1'b1;
    #1;
    $display("t1 async reset: out_valid=%0b out_ctrl=%0h out_data=%0h", out_valid, out_ctrl, out_data);
    chk("t1_valid", 128'(out_valid), 128'(0));
    chk("t1_ctrl",  128'(out_ctrl),  128'(0));
    chk("t1_data",  128'(out_data),  128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("t1_in_ready", 128'(in_ready), 128'(1));

    // T6: random traffic against a queue model of the entries held in the stage
    q.delete();
    last_flush = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 63) == 0);
      in_ctrl   = CW'($urandom);
      in_data   = DW'({$urandom, $urandom, $urandom});
      #1;
      exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
      chk("t6_in_ready", 128'(in_ready),  128'(exp_rdy));
      chk("t6_valid",    128'(out_valid), 128'(q.size() != 0));
      if (q.size() == 0) begin
        chk("t6_bubble_ctrl", 128'(out_ctrl), 128'(0));
      end else begin
        chk("t6_ctrl", 128'(out_ctrl), 128'(q[0].c));
        chk("t6_data", 128'(out_data), 128'(q[0].d));
      end
      if (last_flush) chk("t6_flush_data", 128'(out_data), 128'(0));
      in_f  = in_valid & exp_rdy;
      out_f = (q.size() != 0) & out_ready;
      @(posedge clk);
      if (flush) begin
        q.delete();
      end else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back('{in_ctrl, in_data});
      end
      last_flush = flush;
    end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    $display("t6 random: done, %0d entries left in model", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
